// File: rtl/mc_ctrl_pkg.sv
// Shared definitions for the multicycle MIPS main control unit.
//   state_t   : 4-bit FSM state encoding
//   OP_*      : recognised opcodes (IR[31:26])
//   aluop_t, alusrcb_t, pcsrc_t : datapath select encodings
//   ctrl_t    : bundled control vector produced by mc_ctrl_decode
package mc_ctrl_pkg;

  localparam int unsigned OP_W = 6;

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    FETCH  = 4'd1,
    DECODE = 4'd2,
    MEMADR = 4'd3,
    MEMRD  = 4'd4,
    MEMWB  = 4'd5,
    MEMWR  = 4'd6,
    EXEC   = 4'd7,
    RWB    = 4'd8,
    BRANCH = 4'd9,
    JUMP   = 4'd10,
    ADDIEX = 4'd11,
    ADDIWB = 4'd12
  } state_t;

  localparam logic [OP_W-1:0] OP_R    = 6'b000000;
  localparam logic [OP_W-1:0] OP_LW   = 6'b100011;
  localparam logic [OP_W-1:0] OP_SW   = 6'b101011;
  localparam logic [OP_W-1:0] OP_BEQ  = 6'b000100;
  localparam logic [OP_W-1:0] OP_J    = 6'b000010;
  localparam logic [OP_W-1:0] OP_ADDI = 6'b001000;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } aluop_t;

  typedef enum logic [1:0] {
    SRCB_B     = 2'b00,
    SRCB_FOUR  = 2'b01,
    SRCB_IMM   = 2'b10,
    SRCB_SHIMM = 2'b11
  } alusrcb_t;

  typedef enum logic [1:0] {
    PCSRC_ALU    = 2'b00,
    PCSRC_ALUOUT = 2'b01,
    PCSRC_JUMP   = 2'b10
  } pcsrc_t;

  typedef struct packed {
    logic     pc_write;
    logic     pc_write_cond;
    logic     iord;
    logic     mem_read;
    logic     mem_write;
    logic     ir_write;
    logic     mem_to_reg;
    logic     reg_dst;
    logic     reg_write;
    logic     alu_src_a;
    alusrcb_t alu_src_b;
    aluop_t   alu_op;
    pcsrc_t   pc_source;
    logic     instr_done;
  } ctrl_t;

  function automatic logic op_is_legal(input logic [OP_W-1:0] op);
    return (op == OP_R) || (op == OP_LW) || (op == OP_SW) ||
           (op == OP_BEQ) || (op == OP_J) || (op == OP_ADDI);
  endfunction

endpackage

// File: rtl/mc_ctrl_decode.sv
// Combinational control decode: FSM state (+ mem_ready) -> control vector.
//   state     : current FSM state
//   mem_ready : memory handshake, gates FETCH IRWrite/PCWrite and MEMWR instr_done
//   ctrl      : all datapath controls and instr_done
module mc_ctrl_decode
  import mc_ctrl_pkg::*;
(
  input  state_t state,
  input  logic   mem_ready,
  output ctrl_t  ctrl
);

  always_comb begin
    ctrl = '0;
    unique case (state)
      FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.alu_op    = ALUOP_ADD;
        ctrl.pc_source = PCSRC_ALU;
        // A stalled fetch must not latch IR or advance PC.
        ctrl.ir_write  = mem_ready;
        ctrl.pc_write  = mem_ready;
      end
      DECODE: begin
        ctrl.alu_src_b = SRCB_SHIMM;
        ctrl.alu_op    = ALUOP_ADD;
      end
      MEMADR, ADDIEX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_ADD;
      end
      MEMRD: begin
        ctrl.mem_read = 1'b1;
        ctrl.iord     = 1'b1;
      end
      MEMWR: begin
        ctrl.mem_write  = 1'b1;
        ctrl.iord       = 1'b1;
        ctrl.instr_done = mem_ready;
      end
      MEMWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_B;
        ctrl.alu_op    = ALUOP_FUNCT;
      end
      RWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.reg_dst    = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      ADDIWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_src_b     = SRCB_B;
        ctrl.alu_op        = ALUOP_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = PCSRC_ALUOUT;
        ctrl.instr_done    = 1'b1;
      end
      JUMP: begin
        ctrl.pc_write   = 1'b1;
        ctrl.pc_source  = PCSRC_JUMP;
        ctrl.instr_done = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/mc_control.sv
// Multicycle MIPS main control unit.
//   clk, rst_n  : clock, asynchronous active-low reset
//   opcode      : IR[31:26], stable from the cycle after FETCH completes
//   mem_ready   : memory access completes this cycle
//   PCWrite .. PCSource : datapath controls (Moore, FETCH/MEMWR gated by mem_ready)
//   instr_done  : final cycle of each legal instruction
//   illegal_op  : one-cycle registered flag after decoding an unsupported opcode
// All outputs decode from the state register, so an asynchronous reset drops
// every write enable immediately.
module mc_control
  import mc_ctrl_pkg::*;
#(
  parameter int unsigned OPW = 6
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [OPW-1:0] opcode,
  input  logic           mem_ready,
  output logic           PCWrite,
  output logic           PCWriteCond,
  output logic           IorD,
  output logic           MemRead,
  output logic           MemWrite,
  output logic           IRWrite,
  output logic           MemtoReg,
  output logic           RegDst,
  output logic           RegWrite,
  output logic           ALUSrcA,
  output logic [1:0]     ALUSrcB,
  output logic [1:0]     ALUOp,
  output logic [1:0]     PCSource,
  output logic           instr_done,
  output logic           illegal_op
);

  state_t          state, state_next;
  ctrl_t           ctrl;
  logic [OP_W-1:0] op;
  logic            op_legal;

  assign op       = OP_W'(opcode);
  assign op_legal = op_is_legal(op);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      illegal_op <= 1'b0;
    end else begin
      state      <= state_next;
      illegal_op <= (state == DECODE) && !op_legal;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:   state_next = FETCH;
      FETCH:  state_next = mem_ready ? DECODE : FETCH;
      DECODE: begin
        if ((op == OP_LW) || (op == OP_SW)) state_next = MEMADR;
        else if (op == OP_R)                state_next = EXEC;
        else if (op == OP_BEQ)              state_next = BRANCH;
        else if (op == OP_J)                state_next = JUMP;
        else if (op == OP_ADDI)             state_next = ADDIEX;
        else                                state_next = FETCH;
      end
      MEMADR: state_next = (op == OP_SW) ? MEMWR : MEMRD;
      MEMRD:  state_next = mem_ready ? MEMWB : MEMRD;
      MEMWR:  state_next = mem_ready ? FETCH : MEMWR;
      EXEC:   state_next = RWB;
      ADDIEX: state_next = ADDIWB;
      MEMWB, RWB, ADDIWB, BRANCH, JUMP: state_next = FETCH;
      default: state_next = IDLE;
    endcase
  end

  mc_ctrl_decode u_decode (
    .state     (state),
    .mem_ready (mem_ready),
    .ctrl      (ctrl)
  );

  assign PCWrite     = ctrl.pc_write;
  assign PCWriteCond = ctrl.pc_write_cond;
  assign IorD        = ctrl.iord;
  assign MemRead     = ctrl.mem_read;
  assign MemWrite    = ctrl.mem_write;
  assign IRWrite     = ctrl.ir_write;
  assign MemtoReg    = ctrl.mem_to_reg;
  assign RegDst      = ctrl.reg_dst;
  assign RegWrite    = ctrl.reg_write;
  assign ALUSrcA     = ctrl.alu_src_a;
  assign ALUSrcB     = ctrl.alu_src_b;
  assign ALUOp       = ctrl.alu_op;
  assign PCSource    = ctrl.pc_source;
  assign instr_done  = ctrl.instr_done;

endmodule

// File: tb/tb_mc_control.sv
// Directed bench for mc_control. Each step drives inputs on the falling edge,
// checks the full output vector 1 time unit later, and lets the next rising
// edge advance the FSM.
// Vector bit order: PCWrite PCWriteCond IorD MemRead MemWrite IRWrite MemtoReg
//                   RegDst RegWrite ALUSrcA ALUSrcB[1:0] ALUOp[1:0] PCSource[1:0]
//                   instr_done illegal_op
module tb_mc_control;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
  logic       MemtoReg, RegDst, RegWrite, ALUSrcA;
  logic [1:0] ALUSrcB, ALUOp, PCSource;
  logic       instr_done, illegal_op;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  localparam logic [5:0] R    = 6'b000000;
  localparam logic [5:0] LW   = 6'b100011;
  localparam logic [5:0] SW   = 6'b101011;
  localparam logic [5:0] BEQ  = 6'b000100;
  localparam logic [5:0] J    = 6'b000010;
  localparam logic [5:0] ADDI = 6'b001000;
  localparam logic [5:0] BAD  = 6'b111111;

  //                          PW PC ID MR MW IR M2 RD RW SA SB OP PS DN IL
  localparam logic [17:0] V_IDLE   = 18'b0_0_0_0_0_0_0_0_0_0_00_00_00_0_0;
  localparam logic [17:0] V_FETCH  = 18'b1_0_0_1_0_1_0_0_0_0_01_00_00_0_0;
  localparam logic [17:0] V_FSTALL = 18'b0_0_0_1_0_0_0_0_0_0_01_00_00_0_0;
  localparam logic [17:0] V_FILL   = 18'b1_0_0_1_0_1_0_0_0_0_01_00_00_0_1;
  localparam logic [17:0] V_DEC    = 18'b0_0_0_0_0_0_0_0_0_0_11_00_00_0_0;
  localparam logic [17:0] V_ADR    = 18'b0_0_0_0_0_0_0_0_0_1_10_00_00_0_0;
  localparam logic [17:0] V_MEMRD  = 18'b0_0_1_1_0_0_0_0_0_0_00_00_00_0_0;
  localparam logic [17:0] V_MEMWB  = 18'b0_0_0_0_0_0_1_0_1_0_00_00_00_1_0;
  localparam logic [17:0] V_WRST   = 18'b0_0_1_0_1_0_0_0_0_0_00_00_00_0_0;
  localparam logic [17:0] V_WRDN   = 18'b0_0_1_0_1_0_0_0_0_0_00_00_00_1_0;
  localparam logic [17:0] V_EXEC   = 18'b0_0_0_0_0_0_0_0_0_1_00_10_00_0_0;
  localparam logic [17:0] V_RWB    = 18'b0_0_0_0_0_0_0_1_1_0_00_00_00_1_0;
  localparam logic [17:0] V_ADDIWB = 18'b0_0_0_0_0_0_0_0_1_0_00_00_00_1_0;
  localparam logic [17:0] V_BRANCH = 18'b0_1_0_0_0_0_0_0_0_1_00_01_01_1_0;
  localparam logic [17:0] V_JUMP   = 18'b1_0_0_0_0_0_0_0_0_0_00_00_10_1_0;

  logic [17:0] obs;
  assign obs = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
                RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, instr_done,
                illegal_op};

  mc_control #(.OPW(6)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .opcode      (opcode),
    .mem_ready   (mem_ready),
    .PCWrite     (PCWrite),
    .PCWriteCond (PCWriteCond),
    .IorD        (IorD),
    .MemRead     (MemRead),
    .MemWrite    (MemWrite),
    .IRWrite     (IRWrite),
    .MemtoReg    (MemtoReg),
    .RegDst      (RegDst),
    .RegWrite    (RegWrite),
    .ALUSrcA     (ALUSrcA),
    .ALUSrcB     (ALUSrcB),
    .ALUOp       (ALUOp),
    .PCSource    (PCSource),
    .instr_done  (instr_done),
    .illegal_op  (illegal_op)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [17:0] expv);
    vectors++;
    assert (obs === expv)
    else begin
      miscompares++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
    end
  endtask

  task automatic step(input string tag, input logic mr, input logic [5:0] op,
                      input logic [17:0] expv);
    @(negedge clk);
    mem_ready = mr;
    opcode    = op;
    #1;
    chk(tag, expv);
  endtask

  initial begin
    rst_n     = 1'b0;
    mem_ready = 1'b1;
    opcode    = R;
    repeat (2) @(negedge clk);
    #1;
    chk("reset_idle", V_IDLE);

    // Release: IDLE one cycle, then R-type FETCH, DECODE, EXEC, RWB
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rel_idle", V_IDLE);
    step("r_fetch",  1'b1, R, V_FETCH);
    step("r_decode", 1'b1, R, V_DEC);
    step("r_exec",   1'b1, R, V_EXEC);
    step("r_rwb",    1'b1, R, V_RWB);

    // lw with two MEMRD stall cycles
    step("lw_fetch",  1'b1, LW, V_FETCH);
    step("lw_decode", 1'b1, LW, V_DEC);
    step("lw_memadr", 1'b1, LW, V_ADR);
    step("lw_rd_st1", 1'b0, LW, V_MEMRD);
    step("lw_rd_st2", 1'b0, LW, V_MEMRD);
    step("lw_rd_go",  1'b1, LW, V_MEMRD);
    step("lw_memwb",  1'b1, LW, V_MEMWB);

    // sw with three FETCH stall cycles and one MEMWR stall
    step("sw_f_st1",  1'b0, SW, V_FSTALL);
    step("sw_f_st2",  1'b0, SW, V_FSTALL);
    step("sw_f_st3",  1'b0, SW, V_FSTALL);
    step("sw_f_go",   1'b1, SW, V_FETCH);
    step("sw_decode", 1'b1, SW, V_DEC);
    step("sw_memadr", 1'b1, SW, V_ADR);
    step("sw_wr_st",  1'b0, SW, V_WRST);
    step("sw_wr_go",  1'b1, SW, V_WRDN);

    // beq then j, 3 cycles each
    step("beq_fetch",  1'b1, BEQ, V_FETCH);
    step("beq_decode", 1'b1, BEQ, V_DEC);
    step("beq_branch", 1'b1, BEQ, V_BRANCH);
    step("j_fetch",    1'b1, J,   V_FETCH);
    step("j_decode",   1'b1, J,   V_DEC);
    step("j_jump",     1'b1, J,   V_JUMP);

    // Illegal opcode returns to FETCH with a one-cycle flag
    step("ill_fetch",  1'b1, BAD,  V_FETCH);
    step("ill_decode", 1'b1, BAD,  V_DEC);
    step("ill_flag",   1'b1, ADDI, V_FILL);

    // addi, then asynchronous reset during ADDIWB
    step("addi_decode", 1'b1, ADDI, V_DEC);
    step("addi_ex",     1'b1, ADDI, V_ADR);
    step("addi_wb",     1'b1, ADDI, V_ADDIWB);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_rst", V_IDLE);
    step("rst_hold", 1'b1, R, V_IDLE);

    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rel2_idle", V_IDLE);
    step("rel2_fetch", 1'b1, R, V_FETCH);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mc_control.md
# mc_control

Multicycle main control unit for the MIPS datapath. Sequences each instruction through fetch, decode, execute, memory and write-back states. Drives the datapath mux selects, the memory enables and the register-file write enable `RegWrite`, which is sampled by the register file on the same `clk` edge. Sits directly upstream of the register file: its `RegDst`/`MemtoReg`/`RegWrite` outputs choose the write register and write data presented to it.

## Interface
- `OPW`, 6, opcode width
- `clk`  in  1  system clock; all state changes occur on its rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `opcode`  in  6  `IR[31:26]`; stable from the cycle after FETCH completes
- `mem_ready`  in  1  memory handshake; 1 = access completes this cycle
- `PCWrite`, `PCWriteCond`, `IorD`, `MemRead`, `MemWrite`, `IRWrite`, `MemtoReg`, `RegDst`, `RegWrite`, `ALUSrcA`  out  1 each  datapath controls
- `ALUSrcB`  out  2  00 = B, 01 = const 4, 10 = sign-extended immediate, 11 = shifted immediate
- `ALUOp`  out  2  00 = add, 01 = sub, 10 = funct-decoded
- `PCSource`  out  2  00 = ALU, 01 = ALUOut, 10 = jump target
- `instr_done`  out  1  high in the final cycle of every legal instruction
- `illegal_op`  out  1  registered one-cycle flag for an unsupported opcode

## Operation
- Opcodes:
  - R = 000000
  - lw = 100011
  - sw = 101011
  - beq = 000100
  - j = 000010
  - addi = 001000
- Any other opcode is illegal.
- States: IDLE, FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, RWB, BRANCH, JUMP, ADDIEX, ADDIWB.
- Transitions:
  - IDLE → FETCH.
  - FETCH → DECODE when `mem_ready`; otherwise stay in FETCH.
  - DECODE → MEMADR for lw/sw, EXEC for R, BRANCH for beq, JUMP for j, ADDIEX for addi, FETCH for an illegal opcode.
  - MEMADR → MEMRD for lw, MEMWR for sw.
  - MEMRD → MEMWB when `mem_ready`; otherwise stay.
  - MEMWR → FETCH when `mem_ready`; otherwise stay.
  - EXEC → RWB; ADDIEX → ADDIWB.
  - MEMWB, RWB, ADDIWB, BRANCH, JUMP → FETCH.
- Outputs are Moore, decoded from the state, except for the `mem_ready` gating noted below. Any control not listed for a state is 0.
  - FETCH: `MemRead`=1, `IorD`=0, `ALUSrcA`=0, `ALUSrcB`=01, `ALUOp`=00, `PCSource`=00. `IRWrite` and `PCWrite` = `mem_ready`, so a stalled fetch never double-increments the PC.
  - DECODE: `ALUSrcA`=0, `ALUSrcB`=11, `ALUOp`=00.
  - MEMADR and ADDIEX: `ALUSrcA`=1, `ALUSrcB`=10, `ALUOp`=00.
  - MEMRD: `MemRead`=1, `IorD`=1.
  - MEMWR: `MemWrite`=1, `IorD`=1.
  - MEMWB: `RegWrite`=1, `MemtoReg`=1, `RegDst`=0.
  - EXEC: `ALUSrcA`=1, `ALUSrcB`=00, `ALUOp`=10.
  - RWB: `RegWrite`=1, `RegDst`=1, `MemtoReg`=0.
  - ADDIWB: `RegWrite`=1, `RegDst`=0, `MemtoReg`=0.
  - BRANCH: `ALUSrcA`=1, `ALUSrcB`=00, `ALUOp`=01, `PCWriteCond`=1, `PCSource`=01.
  - JUMP: `PCWrite`=1, `PCSource`=10.
- `instr_done` = 1 in MEMWB, RWB, ADDIWB, BRANCH, JUMP, and in MEMWR only while `mem_ready`=1.
- `illegal_op` is set on the edge that leaves DECODE with an illegal opcode, so it is high during the following FETCH cycle, then clears.
- `RegWrite` is high for exactly one cycle per lw/R/addi instruction and never in any other state.

## Timing
- Reset (`rst_n`=0, asynchronous):
  - state = IDLE; `illegal_op` = 0.
  - All outputs are 0 while in IDLE, including `RegWrite`, `MemWrite` and `PCWrite`.
- Release: IDLE lasts one cycle, then FETCH.
- Latency with `mem_ready` held at 1:
  - lw: 5 cycles
  - R, addi, sw: 4 cycles
  - beq, j: 3 cycles
  - Each stalled cycle (`mem_ready`=0) in FETCH, MEMRD or MEMWR adds one cycle. Outputs are held, except FETCH `IRWrite`/`PCWrite`, which stay 0.
- Reset mid-instruction: state returns to IDLE immediately. Any write-enable high at that moment drops asynchronously, so no partial write-back occurs.
- Illegal opcode: 2 cycles (FETCH, DECODE), with no memory or register write.

## Structure
- Shared package `mc_ctrl_pkg`:
  - 4-bit state encoding constants
  - opcode constants
  - `ALUOp`, `ALUSrcB` and `PCSource` encodings
- Sub-module `mc_ctrl_decode`: purely combinational state (+ `mem_ready`) → control vector.
- `mc_control` holds the state register, next-state logic and the `illegal_op` flop.

## Test plan
- Reset held, then released with `opcode`=000000 and `mem_ready`=1 → sequence IDLE, FETCH, DECODE, EXEC, RWB. `RegWrite`=1, `RegDst`=1 only in RWB (5th cycle after release); `instr_done` high in RWB.
- lw (100011), `mem_ready` low for 2 cycles in MEMRD → MEMRD lasts 3 cycles; `MemRead`=`IorD`=1 throughout; MEMWB follows with `RegWrite`=1, `MemtoReg`=1.
- sw (101011), `mem_ready`=0 for 3 cycles in FETCH → `PCWrite`=`IRWrite`=0 while stalled, 1 in the release cycle. `MemWrite` pulses in MEMWR; `RegWrite` never asserted.
- beq then j back-to-back → BRANCH shows `PCWriteCond`=1, `ALUOp`=01, `PCSource`=01; JUMP shows `PCWrite`=1, `PCSource`=10; each instruction takes 3 cycles.
- Opcode 111111 → DECODE goes to FETCH; `illegal_op`=1 for exactly one cycle; no write-enable asserts.
- `rst_n` dropped during ADDIWB → `RegWrite` falls asynchronously; state is IDLE and all outputs are 0 before the next edge.
